// File: rtl/transfer_pkg.sv
// -----------------------------------------------------------------------------
// transfer_pkg
//   Shared definitions for the transmit side of the 8-bit serial transfer link.
//   Holds the frame width, the slot counter geometry, the command byte values
//   understood by the receiving transfer center, the idle frame value and the
//   scheduler FSM state type.
// -----------------------------------------------------------------------------
package transfer_pkg;

    // Frame width in bits; the link is fixed at 8.
    localparam int FRAME_W = 8;

    // Slot counter geometry: one slot per serial bit of a frame.
    localparam int                SLOT_W    = $clog2(FRAME_W);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);

    // Command bytes as the transfer center decodes them.
    localparam logic [FRAME_W-1:0] CMD_50     = 8'd1;
    localparam logic [FRAME_W-1:0] CMD_80     = 8'd2;
    localparam logic [FRAME_W-1:0] CMD_90     = 8'd3;
    localparam logic [FRAME_W-1:0] CMD_100    = 8'd4;
    localparam logic [FRAME_W-1:0] CMD_FLUSH  = 8'd5;
    localparam logic [FRAME_W-1:0] CMD_READY  = 8'd6;
    localparam logic [FRAME_W-1:0] CMD_BINARY = 8'd7;
    localparam logic [FRAME_W-1:0] CMD_ASCII  = 8'd8;

    // Frame sent whenever nothing is scheduled.
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 8'd0;

    // Scheduler state, decided only at frame load edges.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Only the binary command is followed by a data frame; every other value,
    // including out-of-range ones, is a single frame.
    function automatic logic is_binary(input logic [FRAME_W-1:0] cmd_byte);
        return (cmd_byte == CMD_BINARY);
    endfunction

endpackage

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
//   Free-running frame timing and parallel-to-serial conversion for the link.
//   A slot counter walks 0..7 continuously; the edge on which it sits at 7 is
//   the load edge, where the shift register takes load_value. On every other
//   edge the register shifts left, so the line carries the frame MSB first.
//
// Ports
//   clk          in   link clock, one serial bit per rising edge
//   rst          in   asynchronous active-low reset
//   load_value   in   frame byte captured at the load edge
//   load         out  high during the cycle whose rising edge is a load edge
//   serial_out   out  serial data, MSB first
//   frame_start  out  high while bit 0 (MSB) of a frame is on the line
// -----------------------------------------------------------------------------
module frame_serializer
    import transfer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] load_value,
    output logic               load,
    output logic               serial_out,
    output logic               frame_start
);

    logic [SLOT_W-1:0]  slot_reg;
    logic [FRAME_W-1:0] shift_reg;

    // Reset parks the counter on the last slot so the very first edge after
    // reset release loads a frame.
    assign load = (slot_reg == SLOT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_reg  <= SLOT_LAST;
            shift_reg <= '0;
        end else begin
            slot_reg <= slot_reg + 1'b1;
            if (load) begin
                shift_reg <= load_value;
            end else begin
                shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign serial_out  = shift_reg[FRAME_W-1];
    // Slot 0 is the cycle right after a load edge, i.e. the MSB of the frame.
    assign frame_start = (slot_reg == '0);

endmodule

// File: rtl/transfer_scheduler.sv
// -----------------------------------------------------------------------------
// transfer_scheduler
//   Transmit-side controller for the 8-bit serial transfer link. Arbitrates
//   between two scanner command sources, sends the winner's command frame and,
//   after a binary command, the trailing data frame. Frames are back-to-back;
//   when nothing is scheduled an idle frame (all zeros) is sent.
//
// Build option
//   TRANSFER_RR_EN  defined   : round-robin arbitration with a 1-bit pointer
//                   undefined : fixed priority, requester 0 always wins
//
// Ports
//   clk                 in   link clock, one serial bit per rising edge
//   rst                 in   asynchronous active-low reset
//   req[1:0]            in   per-requester request, held until its gnt bit
//   cmd0, cmd1          in   command byte of requester 0 / 1
//   data0, data1        in   data byte, used only after a binary command
//   readyForTransferIn  in   link partner ready; low forces idle frames
//   gnt[1:0]            out  one-cycle grant, aligned with the command MSB
//   serialOut           out  serial data, MSB first
//   frameStart          out  high during bit 0 (MSB) of every frame
//   busy                out  high while a command or data frame is in flight
// -----------------------------------------------------------------------------
module transfer_scheduler
    import transfer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [FRAME_W-1:0] cmd0,
    input  logic [FRAME_W-1:0] cmd1,
    input  logic [FRAME_W-1:0] data0,
    input  logic [FRAME_W-1:0] data1,
    input  logic               readyForTransferIn,
    output logic [1:0]         gnt,
    output logic               serialOut,
    output logic               frameStart,
    output logic               busy
);

    localparam int NUM_REQ = 2;

    // Requester inputs gathered into arrays so the winner can index them.
    logic [FRAME_W-1:0] cmd_arr  [NUM_REQ];
    logic [FRAME_W-1:0] data_arr [NUM_REQ];

    assign cmd_arr[0]  = cmd0;
    assign cmd_arr[1]  = cmd1;
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;

    // FSM and datapath state
    state_t             state_reg, state_next;
    logic [FRAME_W-1:0] hold_reg, hold_next;   // data byte of the last winner
    logic               bin_reg, bin_next;     // current CMD frame is binary
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;

    // Serializer handshake
    logic               load;
    logic [FRAME_W-1:0] load_value;

    // Arbitration
    logic               data_pending;
    logic               grant_valid;
    logic               winner;
    logic [NUM_REQ-1:0] winner_onehot;

    // A binary command owns the next frame outright: its data byte goes out
    // regardless of requests or of readyForTransferIn.
    assign data_pending = (state_reg == CMD) && bin_reg;
    assign grant_valid  = !data_pending && readyForTransferIn && (|req);

`ifdef TRANSFER_RR_EN
    // Round robin: the pointer names the preferred requester; after a grant it
    // moves to the requester that did not win.
    logic ptr_reg;

    always_comb begin
        if (ptr_reg) begin
            winner = req[1] ? 1'b1 : 1'b0;
        end else begin
            winner = req[0] ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= 1'b0;
        end else if (load && grant_valid) begin
            ptr_reg <= ~winner;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is quiet.
    assign winner = ~req[0];
`endif

    // One-hot grant vector for the winner, qualified by a real grant.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign winner_onehot[gi] = grant_valid && (winner == 1'(gi));
    end

    // Next-state and frame selection; only applied at load edges.
    always_comb begin
        state_next = IDLE;
        load_value = IDLE_FRAME;
        hold_next  = hold_reg;
        bin_next   = 1'b0;
        gnt_next   = '0;

        if (data_pending) begin
            state_next = DATA;
            load_value = hold_reg;
        end else if (grant_valid) begin
            state_next = CMD;
            load_value = cmd_arr[winner];
            hold_next  = data_arr[winner];
            bin_next   = is_binary(cmd_arr[winner]);
            gnt_next   = winner_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            bin_reg   <= 1'b0;
        end else if (load) begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            bin_reg   <= bin_next;
        end
    end

    // The grant is registered so it lines up with the command MSB and lasts
    // exactly one cycle; reset clears it at once, so an aborted frame leaves
    // no grant behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_reg <= '0;
        end else begin
            gnt_reg <= load ? gnt_next : '0;
        end
    end

    frame_serializer u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load_value  (load_value),
        .load        (load),
        .serial_out  (serialOut),
        .frame_start (frameStart)
    );

    assign gnt  = gnt_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_transfer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_transfer_scheduler
//   Self-checking bench for transfer_scheduler. A reference model computes the
//   frame each load edge should produce and pushes it to a scoreboard queue
//   when the stimulus is driven; each captured frame pops and compares one
//   entry. Arbitration expectations follow TRANSFER_RR_EN.
// -----------------------------------------------------------------------------
module tb_transfer_scheduler;
    import transfer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] cmd0, cmd1, data0, data1;
    logic       ready;
    logic [1:0] gnt;
    logic       serialOut, frameStart, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] frame;
        logic [1:0] g;
        int         busy_n;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic       m_bin;
    logic [7:0] m_hold;
`ifdef TRANSFER_RR_EN
    logic       m_ptr;
`endif

    transfer_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .cmd0               (cmd0),
        .cmd1               (cmd1),
        .data0              (data0),
        .data1              (data1),
        .readyForTransferIn (ready),
        .gnt                (gnt),
        .serialOut          (serialOut),
        .frameStart         (frameStart),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_bin  = 1'b0;
        m_hold = 8'h00;
`ifdef TRANSFER_RR_EN
        m_ptr  = 1'b0;
`endif
        exp_q.delete();
    endtask

    // Predict the frame produced by the next load edge for the given inputs.
    task automatic model_push(input logic [1:0] r, input logic rdy);
        exp_t       e;
        logic       w;
        logic [7:0] c;
        if (m_bin) begin
            e.frame = m_hold; e.g = 2'b00; e.busy_n = 8;
            m_bin = 1'b0;
        end else if (rdy && (r != 2'b00)) begin
`ifdef TRANSFER_RR_EN
            if (r[m_ptr]) w = m_ptr;
            else          w = ~m_ptr;
            m_ptr = ~w;
`else
            w = r[0] ? 1'b0 : 1'b1;
`endif
            c = w ? cmd1 : cmd0;
            e.frame = c;
            e.g = w ? 2'b10 : 2'b01;
            e.busy_n = 8;
            m_hold = w ? data1 : data0;
            m_bin  = (c == CMD_BINARY);
        end else begin
            e.frame = IDLE_FRAME; e.g = 2'b00; e.busy_n = 0;
        end
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the negedge carrying frameStart.
    task automatic sync_frame(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 16) begin
            @(negedge clk);
            n++;
            if (frameStart === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Capture the next whole frame; returns at the negedge of its last bit.
    task automatic capture_frame(output logic [7:0] fv, output logic [1:0] g0,
                                 output logic [1:0] g_rest, output int busy_n,
                                 output logic fs_extra, output bit ok);
        logic [7:0] v = 8'h00;
        sync_frame(ok);
        g0 = 2'b00; g_rest = 2'b00; busy_n = 0; fs_extra = 1'b0;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    g_rest = g_rest | gnt;
                    if (frameStart !== 1'b0) fs_extra = 1'b1;
                end else begin
                    g0 = gnt;
                end
                v = {v[6:0], serialOut};
                if (busy === 1'b1) busy_n++;
            end
        end
        fv = v;
    endtask

    task automatic test_reset();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        rst = 1'b0; req = 2'b00; ready = 1'b1;
        cmd0 = 8'h00; cmd1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (serialOut !== 1'b0) begin errors++; $display("FAIL reset_serialOut: got %b, expected 0", serialOut); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b, expected 00", gnt); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL reset_frameStart: got %b, expected 0", frameStart); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL reset_first_frame: frameStart %b, expected 1", frameStart); end
        for (int k = 0; k < 2; k++) begin
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL reset_idle[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (fv !== e.frame) begin errors++; $display("FAIL reset_idle[%0d]: frame %h, expected %h", k, fv, e.frame); end
                checks++; if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL reset_idle_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (bn != e.busy_n || fsx !== 1'b0) begin errors++; $display("FAIL reset_idle_busy[%0d]: busy %0d fsx %b, expected %0d 0", k, bn, fsx, e.busy_n); end
            end
            $display("reset idle frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
        end
    endtask

    task automatic test_single();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_sync: no frameStart, got 0 expected 1"); end
        cmd0 = CMD_90; data0 = 8'h5A; req = 2'b01;
        for (int k = 0; k < 2; k++) begin
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL single[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (fv !== e.frame) begin errors++; $display("FAIL single[%0d]: frame %h, expected %h", k, fv, e.frame); end
                checks++; if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL single_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (bn != e.busy_n || fsx !== 1'b0) begin errors++; $display("FAIL single_busy[%0d]: busy %0d fsx %b, expected %0d 0", k, bn, fsx, e.busy_n); end
            end
            $display("single frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
            req = req & ~g0;
        end
    endtask

    task automatic test_binary();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL binary_sync: no frameStart, got 0 expected 1"); end
        cmd1 = CMD_BINARY; data1 = 8'hA5; req = 2'b10;
        for (int k = 0; k < 3; k++) begin
            // Partner not ready while the data frame is pending: must not matter.
            if (k == 1) ready = 1'b0;
            if (k == 2) ready = 1'b1;
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL binary[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (fv !== e.frame) begin errors++; $display("FAIL binary[%0d]: frame %h, expected %h", k, fv, e.frame); end
                checks++; if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL binary_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (bn != e.busy_n || fsx !== 1'b0) begin errors++; $display("FAIL binary_busy[%0d]: busy %0d fsx %b, expected %0d 0", k, bn, fsx, e.busy_n); end
            end
            $display("binary frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
            req = req & ~g0;
        end
    endtask

    task automatic test_ready_low();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ready_sync: no frameStart, got 0 expected 1"); end
        ready = 1'b0; cmd0 = CMD_FLUSH; data0 = 8'h11; req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ready = 1'b1;
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL ready_low[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (fv !== e.frame) begin errors++; $display("FAIL ready_low[%0d]: frame %h, expected %h", k, fv, e.frame); end
                checks++; if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL ready_low_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (bn != e.busy_n || fsx !== 1'b0) begin errors++; $display("FAIL ready_low_busy[%0d]: busy %0d fsx %b, expected %0d 0", k, bn, fsx, e.busy_n); end
            end
            $display("ready_low frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
            req = req & ~g0;
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_sync: no frameStart, got 0 expected 1"); end
        cmd0 = 8'hFF; data0 = 8'h00; req = 2'b01;
        sync_frame(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midrst_frame: no frameStart within 16 cycles");
        end else begin
            if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_gnt_bit0: gnt %b, expected 01", gnt); end
            repeat (4) @(negedge clk);
            checks++; if (serialOut !== 1'b1) begin errors++; $display("FAIL midrst_bit4: serialOut %b, expected 1", serialOut); end
            rst = 1'b0; req = 2'b00;
            #1;
            checks++; if (serialOut !== 1'b0) begin errors++; $display("FAIL midrst_serialOut: got %b, expected 0", serialOut); end
            checks++; if (gnt !== 2'b00 || busy !== 1'b0 || frameStart !== 1'b0) begin
                errors++; $display("FAIL midrst_outputs: gnt %b busy %b frameStart %b, expected 00 0 0", gnt, busy, frameStart);
            end
            @(negedge clk);
            rst = 1'b1;
            model_reset();
            @(negedge clk);
            checks++; if (frameStart !== 1'b1 || gnt !== 2'b00 || serialOut !== 1'b0) begin
                errors++; $display("FAIL midrst_release: frameStart %b gnt %b serialOut %b, expected 1 00 0", frameStart, gnt, serialOut);
            end
        end
        $display("reset mid-frame: released, frameStart=%b gnt=%b", frameStart, gnt);
    endtask

    task automatic test_alternate();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL alt_sync: no frameStart, got 0 expected 1"); end
        cmd0 = CMD_50; cmd1 = CMD_50; data0 = 8'h00; data1 = 8'h00; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL alternate[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL alternate_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (fv !== e.frame || bn != e.busy_n) begin errors++; $display("FAIL alternate[%0d]: frame %h busy %0d, expected %h %0d", k, fv, bn, e.frame, e.busy_n); end
            end
            $display("alternate frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
        end
        req = 2'b00;
    endtask

    task automatic test_contention_binary();
        logic [7:0] fv; logic [1:0] g0, gr; int bn; logic fsx; bit ok; exp_t e;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_sync: no frameStart, got 0 expected 1"); end
        // Idle frame from the end of the previous test flushes the model.
        model_push(req, ready);
        void'(exp_q.pop_front());
        cmd0 = CMD_BINARY; data0 = 8'h3C; cmd1 = CMD_80; data1 = 8'hC3; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            model_push(req, ready);
            capture_frame(fv, g0, gr, bn, fsx, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL contention[%0d]: no frameStart within 16 cycles", k); end
            else begin
                if (fv !== e.frame) begin errors++; $display("FAIL contention[%0d]: frame %h, expected %h", k, fv, e.frame); end
                checks++; if (g0 !== e.g || gr !== 2'b00) begin errors++; $display("FAIL contention_gnt[%0d]: gnt %b/%b, expected %b/00", k, g0, gr, e.g); end
                checks++; if (bn != e.busy_n || fsx !== 1'b0) begin errors++; $display("FAIL contention_busy[%0d]: busy %0d fsx %b, expected %0d 0", k, bn, fsx, e.busy_n); end
            end
            $display("contention frame %0d: data=%h gnt=%b busy_cycles=%0d", k, fv, g0, bn);
            req = req & ~g0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_binary();
        test_ready_low();
        test_reset_midframe();
        test_alternate();
        test_contention_binary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
